// File: rtl/hazard_unit_mc.sv
// hazard_unit_mc: hazard/forwarding controller for a 5-stage in-order RV pipeline.
//
// Handles operand forwarding into E, load-use stalls of LOAD_LAT bubbles
// (x0 excluded), and stalls for a multi-cycle execute unit (MDU). A taken
// branch in E flushes D/E and cancels any pending load-use stall.
//
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   Rs1D, Rs2D                 source registers in D
//   Rs1E, Rs2E, RdE            sources / destination in E
//   RdM, RdW                   destinations in M / W
//   reg_writeM, reg_writeW     register write enables in M / W
//   result_srcE                result select in E (2'b01 = load)
//   pc_srcE                    taken branch/jump resolved in E
//   mdu_startE, mdu_done       multi-cycle op in E / MDU result valid
//   forward_AE, forward_BE     00 regfile, 01 W result, 10 M ALU result
//   stallF, stallD, stallE     hold PC / IF-ID / ID-EX
//   flushD, flushE, flushM     bubble IF-ID / ID-EX / EX-MEM
//   stall_cycles, flush_cycles saturating performance counters
//
// Optional feature: define HAZARD_PERF_CNT_EN to build the performance
// counters. Without it both counter ports are tied to zero.

module hazard_unit_mc #(
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic [REG_AW-1:0] Rs1E,
    input  logic [REG_AW-1:0] Rs2E,
    input  logic [REG_AW-1:0] RdE,
    input  logic [REG_AW-1:0] RdM,
    input  logic [REG_AW-1:0] RdW,
    input  logic              reg_writeM,
    input  logic              reg_writeW,
    input  logic [1:0]        result_srcE,
    input  logic              pc_srcE,
    input  logic              mdu_startE,
    input  logic              mdu_done,
    output logic [1:0]        forward_AE,
    output logic [1:0]        forward_BE,
    output logic              stallF,
    output logic              stallD,
    output logic              stallE,
    output logic              flushD,
    output logic              flushE,
    output logic              flushM,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  flush_cycles
);

    localparam int unsigned LCNT_W = $clog2(LOAD_LAT) + 1;

    typedef enum logic [0:0] {StIdle, StBusy} mdu_state_e;

    // ------------------------------------------------------------------
    // Forwarding: M beats W, x0 never forwards.
    // ------------------------------------------------------------------
    always_comb begin
        forward_AE = 2'b00;
        if (Rs1E != '0) begin
            if (reg_writeM && (Rs1E == RdM)) begin
                forward_AE = 2'b10;
            end else if (reg_writeW && (Rs1E == RdW)) begin
                forward_AE = 2'b01;
            end
        end
    end

    always_comb begin
        forward_BE = 2'b00;
        if (Rs2E != '0) begin
            if (reg_writeM && (Rs2E == RdM)) begin
                forward_BE = 2'b10;
            end else if (reg_writeW && (Rs2E == RdW)) begin
                forward_BE = 2'b01;
            end
        end
    end

    // ------------------------------------------------------------------
    // Load-use stall. The hit cycle is the first bubble; lcnt covers the
    // remaining LOAD_LAT-1 bubbles.
    // ------------------------------------------------------------------
    logic [LCNT_W-1:0] lcnt_q, lcnt_d;
    logic              ld_hit;
    logic              lstall;

    assign ld_hit = (result_srcE == 2'b01) && (RdE != '0) &&
                    ((Rs1D == RdE) || (Rs2D == RdE)) &&
                    !pc_srcE && (lcnt_q == '0);
    assign lstall = ld_hit || (lcnt_q != '0);

    always_comb begin
        lcnt_d = lcnt_q;
        if (pc_srcE) begin
            // The dependent instruction in D is being flushed.
            lcnt_d = '0;
        end else if (ld_hit) begin
            lcnt_d = LCNT_W'(LOAD_LAT - 1);
        end else if (lcnt_q != '0) begin
            lcnt_d = lcnt_q - LCNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lcnt_q <= '0;
        end else begin
            lcnt_q <= lcnt_d;
        end
    end

    // ------------------------------------------------------------------
    // MDU stall FSM. A start that completes in the same cycle never stalls.
    // ------------------------------------------------------------------
    mdu_state_e state_q, state_d;
    logic       mstall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mstall  = 1'b0;
        case (state_q)
            StIdle: begin
                if (mdu_startE && !mdu_done && !pc_srcE) begin
                    state_d = StBusy;
                    mstall  = 1'b1;
                end
            end
            StBusy: begin
                if (mdu_done) begin
                    state_d = StIdle;
                end else begin
                    mstall = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // ------------------------------------------------------------------
    // Stall / flush combination. E is never bubbled while it holds the MDU op.
    // ------------------------------------------------------------------
    logic stall_fd;

    always_comb begin
        stall_fd = (lstall || mstall) && !pc_srcE;
        stallF   = stall_fd;
        stallD   = stall_fd;
        stallE   = mstall;
        flushD   = pc_srcE;
        flushE   = (pc_srcE || lstall) && !mstall;
        flushM   = mstall;
    end

    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------
`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_fd && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if ((flushD || flushE || flushM) && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

    assign stall_cycles = stall_cnt_q;
    assign flush_cycles = flush_cnt_q;
`else
    assign stall_cycles = '0;
    assign flush_cycles = '0;
`endif

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Self-checking bench for hazard_unit_mc, built with LOAD_LAT = 3.
module tb_hazard_unit_mc;

    localparam int unsigned REG_AW   = 5;
    localparam int unsigned LOAD_LAT = 3;
    localparam int unsigned CNT_W    = 32;

`ifdef HAZARD_PERF_CNT_EN
    localparam logic [63:0] PERF_STALL_EXP = 64'd4;
    localparam logic [63:0] PERF_FLUSH_EXP = 64'd4;
`else
    localparam logic [63:0] PERF_STALL_EXP = 64'd0;
    localparam logic [63:0] PERF_FLUSH_EXP = 64'd0;
`endif

    // Expected-output encoding: {fwdA[1:0], fwdB[1:0], sF, sD, sE, fD, fE, fM}
    localparam logic [10:0] O_NONE = 11'b00_00_000_000;
    localparam logic [10:0] O_LD   = 11'b00_00_110_010;
    localparam logic [10:0] O_BR   = 11'b00_00_000_110;
    localparam logic [10:0] O_MDU  = 11'b00_00_111_001;

    logic              clk;
    logic              rst_n;
    logic [REG_AW-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic              reg_writeM, reg_writeW;
    logic [1:0]        result_srcE;
    logic              pc_srcE, mdu_startE, mdu_done;
    logic [1:0]        forward_AE, forward_BE;
    logic              stallF, stallD, stallE, flushD, flushE, flushM;
    logic [CNT_W-1:0]  stall_cycles, flush_cycles;

    hazard_unit_mc #(
        .REG_AW  (REG_AW),
        .LOAD_LAT(LOAD_LAT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .Rs1D        (Rs1D),
        .Rs2D        (Rs2D),
        .Rs1E        (Rs1E),
        .Rs2E        (Rs2E),
        .RdE         (RdE),
        .RdM         (RdM),
        .RdW         (RdW),
        .reg_writeM  (reg_writeM),
        .reg_writeW  (reg_writeW),
        .result_srcE (result_srcE),
        .pc_srcE     (pc_srcE),
        .mdu_startE  (mdu_startE),
        .mdu_done    (mdu_done),
        .forward_AE  (forward_AE),
        .forward_BE  (forward_BE),
        .stallF      (stallF),
        .stallD      (stallD),
        .stallE      (stallE),
        .flushD      (flushD),
        .flushE      (flushE),
        .flushM      (flushM),
        .stall_cycles(stall_cycles),
        .flush_cycles(flush_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
        logic        rwm, rww;
        logic [1:0]  rsrc;
        logic        pcs, start, done;
        logic [10:0] exp;
    } vec_t;

    vec_t        vecs[$];
    logic [10:0] exp_q[$];
    int          total = 0;
    int          bad   = 0;

    function automatic vec_t mk(input logic [4:0] rs1d, input logic [4:0] rs2d,
                                input logic [4:0] rs1e, input logic [4:0] rs2e,
                                input logic [4:0] rde, input logic [4:0] rdm,
                                input logic [4:0] rdw, input logic rwm, input logic rww,
                                input logic [1:0] rsrc, input logic pcs,
                                input logic start, input logic done,
                                input logic [10:0] exp);
        vec_t v;
        v.rs1d = rs1d; v.rs2d = rs2d; v.rs1e = rs1e; v.rs2e = rs2e;
        v.rde = rde; v.rdm = rdm; v.rdw = rdw; v.rwm = rwm; v.rww = rww;
        v.rsrc = rsrc; v.pcs = pcs; v.start = start; v.done = done; v.exp = exp;
        return v;
    endfunction

    function automatic vec_t zv(input logic [10:0] exp);
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, exp);
    endfunction

    function automatic logic [10:0] outs();
        return {forward_AE, forward_BE, stallF, stallD, stallE, flushD, flushE, flushM};
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic drive(input vec_t v);
        Rs1D = v.rs1d; Rs2D = v.rs2d; Rs1E = v.rs1e; Rs2E = v.rs2e;
        RdE = v.rde; RdM = v.rdm; RdW = v.rdw;
        reg_writeM = v.rwm; reg_writeW = v.rww; result_srcE = v.rsrc;
        pc_srcE = v.pcs; mdu_startE = v.start; mdu_done = v.done;
    endtask

    // One pipeline cycle: drive, queue the expectation, compare at negedge, advance.
    task automatic run_vec(input vec_t v, input string name);
        logic [10:0] e;
        drive(v);
        exp_q.push_back(v.exp);
        @(negedge clk);
        e = exp_q.pop_front();
        chk(name, {53'd0, outs()}, {53'd0, e});
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(zv(O_NONE));

        // ---------------- vector table ----------------
        vecs.push_back(zv(O_NONE));
        vecs.push_back(mk(0, 0, 5, 0, 0, 5, 5, 1, 1, 2'b00, 0, 0, 0, 11'b10_00_000_000));
        vecs.push_back(mk(0, 0, 5, 0, 0, 6, 5, 1, 1, 2'b00, 0, 0, 0, 11'b01_00_000_000));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 2'b00, 0, 0, 0, O_NONE));
        vecs.push_back(mk(0, 0, 3, 9, 0, 3, 9, 1, 1, 2'b00, 0, 0, 0, 11'b10_01_000_000));
        vecs.push_back(mk(0, 0, 0, 4, 0, 4, 4, 0, 1, 2'b00, 0, 0, 0, 11'b00_01_000_000));
        vecs.push_back(mk(0, 0, 8, 8, 0, 8, 0, 1, 1, 2'b00, 0, 0, 0, 11'b10_10_000_000));
        // Load into x0 never stalls, even though Rs1D == RdE == 0
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 0, 0, 0, O_NONE));
        // Matching registers but not a load
        vecs.push_back(mk(0, 7, 0, 0, 7, 0, 0, 0, 0, 2'b10, 0, 0, 0, O_NONE));
        // Load-use with LOAD_LAT = 3: three bubbles, then clear
        vecs.push_back(mk(0, 7, 0, 0, 7, 0, 0, 0, 0, 2'b01, 0, 0, 0, O_LD));
        vecs.push_back(zv(O_LD));
        vecs.push_back(zv(O_LD));
        vecs.push_back(zv(O_NONE));
        // Branch in the cycle after a hazard cancels the remaining bubbles
        vecs.push_back(mk(7, 0, 0, 0, 7, 0, 0, 0, 0, 2'b01, 0, 0, 0, O_LD));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0, 0, O_BR));
        vecs.push_back(zv(O_NONE));
        // Branch together with a hazard: no stall, counter never loaded
        vecs.push_back(mk(7, 0, 0, 0, 7, 0, 0, 0, 0, 2'b01, 1, 0, 0, O_BR));
        vecs.push_back(zv(O_NONE));
        // MDU: start at cycle 0, done at cycle 4
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 0, O_MDU));
        vecs.push_back(zv(O_MDU));
        vecs.push_back(zv(O_MDU));
        vecs.push_back(zv(O_MDU));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1, O_NONE));
        vecs.push_back(zv(O_NONE));
        // One-cycle MDU op, stray done, start under a taken branch
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 1, O_NONE));
        vecs.push_back(zv(O_NONE));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1, O_NONE));
        vecs.push_back(zv(O_NONE));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 1, 0, O_BR));
        vecs.push_back(zv(O_NONE));

        // ---------------- reset state ----------------
        #1;
        chk("reset_outs", {53'd0, outs()}, 64'd0);
        chk("reset_stall_cnt", {32'd0, stall_cycles}, 64'd0);
        chk("reset_flush_cnt", {32'd0, flush_cycles}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // ---------------- async reset during MDU busy ----------------
        run_vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 0, O_MDU), "mrst_c0");
        run_vec(zv(O_MDU), "mrst_c1");
        drive(zv(O_NONE));
        #2;
        chk("mrst_pre", {53'd0, outs()}, {53'd0, O_MDU});
        rst_n = 1'b0;
        #1;
        chk("mrst_async", {53'd0, outs()}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_vec(zv(O_NONE), "mrst_idle");

        // ---------------- async reset during load stall ----------------
        run_vec(mk(0, 7, 0, 0, 7, 0, 0, 0, 0, 2'b01, 0, 0, 0, O_LD), "lrst_c0");
        drive(zv(O_NONE));
        #2;
        chk("lrst_pre", {53'd0, outs()}, {53'd0, O_LD});
        rst_n = 1'b0;
        #1;
        chk("lrst_async", {53'd0, outs()}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_vec(zv(O_NONE), "lrst_cnt0");

        // ---------------- performance counters over one MDU op ----------------
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        chk("perf_clr_stall", {32'd0, stall_cycles}, 64'd0);
        chk("perf_clr_flush", {32'd0, flush_cycles}, 64'd0);
        run_vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 0, O_MDU), "perf_c0");
        run_vec(zv(O_MDU), "perf_c1");
        run_vec(zv(O_MDU), "perf_c2");
        run_vec(zv(O_MDU), "perf_c3");
        run_vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1, O_NONE), "perf_c4");
        run_vec(zv(O_NONE), "perf_c5");
        chk("perf_stall_cycles", {32'd0, stall_cycles}, PERF_STALL_EXP);
        chk("perf_flush_cycles", {32'd0, flush_cycles}, PERF_FLUSH_EXP);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_unit_mc.md
Name: hazard_unit_mc

Overview:
Parametrised hazard/forwarding controller for the 5-stage in-order RV pipeline (F/D/E/M/W).
- Generalises register address width and load-use latency.
- Adds x0 exclusion on load-use detection.
- Adds a multi-cycle execute-unit (MDU) stall FSM with stallE/flushM.
- Sits beside the datapath; drives forwarding muxes in E and stall/flush enables of all pipeline registers.

Parameters:
REG_AW, 5, register index width.
LOAD_LAT, 1, bubbles inserted per load-use hazard (legal 1..4; 1 = classic single bubble).
CNT_W, 32, width of optional performance counters.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
Rs1D, Rs2D  input  REG_AW  source registers in D
Rs1E, Rs2E, RdE  input  REG_AW  sources/destination in E
RdM, RdW  input  REG_AW  destinations in M/W
reg_writeM, reg_writeW  input  1  write enables in M/W
result_srcE  input  2  result select in E; 2'b01 = load
pc_srcE  input  1  taken branch/jump resolved in E
mdu_startE  input  1  multi-cycle op occupies E this cycle
mdu_done  input  1  MDU result valid this cycle
forward_AE, forward_BE  output  2  00 = regfile, 01 = W result, 10 = M ALU result
stallF, stallD, stallE  output  1  hold PC / IF-ID / ID-EX
flushD, flushE, flushM  output  1  bubble IF-ID / ID-EX / EX-MEM
stall_cycles, flush_cycles  output  CNT_W  performance counters (see Optional Feature)

Behaviour:
- Reset (rst_n low, async): FSM = IDLE, load counter lcnt = 0, perf counters = 0.
- Outputs are combinational from state + inputs. With reset state and all inputs 0, every output is 0.
- Forwarding (combinational): for each operand, if Rs != 0:
  - Rs == RdM & reg_writeM -> 10
  - else Rs == RdW & reg_writeW -> 01
  - else 00
  - M has priority over W. Rs == 0 always yields 00.
- Load-use hit: ld_hit = result_srcE == 01 & RdE != 0 & (Rs1D == RdE | Rs2D == RdE) & !pc_srcE & lcnt == 0.
- Load stall lstall = ld_hit | (lcnt != 0). lstall drives stallF = stallD = 1 and flushE = 1.
- lcnt register (width ceil(log2(LOAD_LAT)) + 1):
  - on ld_hit, lcnt <= LOAD_LAT - 1
  - else if lcnt != 0, lcnt <= lcnt - 1
  - pc_srcE forces lcnt <= 0 (D instruction is being flushed)
- Total bubbles per hazard = LOAD_LAT. The LOAD_LAT = 1 timing is single-cycle, identical to the classic unit.
- MDU FSM, states IDLE and BUSY:
  - IDLE -> BUSY when mdu_startE & !mdu_done & !pc_srcE.
  - BUSY -> IDLE when mdu_done.
  - mstall = (IDLE & mdu_startE & !mdu_done & !pc_srcE) | (BUSY & !mdu_done).
  - mstall drives stallF = stallD = stallE = 1 and flushM = 1. A one-cycle MDU (start & done together) causes no stall.
- Priority:
  - pc_srcE: flushD = flushE = 1 and suppresses lstall/mstall-induced stallF/stallD.
  - mstall overrides lstall: flushE is forced 0 while stallE is 1, because E holds the MDU op.
- Reset mid-stall: lcnt/FSM clear immediately and stalls drop asynchronously.
- mdu_done while IDLE without start: ignored.

Optional Feature:
Macro HAZARD_PERF_CNT_EN.
- Defined:
  - stall_cycles increments each cycle stallF = 1.
  - flush_cycles increments each cycle flushD | flushE | flushM = 1.
  - Both saturate at all-ones (no wrap) and clear on reset.
- Undefined: both ports remain present and are tied to 0. No counter flops are synthesised.

Test Plan:
- Forwarding: Rs1E = 5, RdM = 5, reg_writeM = 1, RdW = 5, reg_writeW = 1 -> forward_AE = 10. Change RdM = 6 -> 01. Rs1E = 0 with all matching -> 00.
- Load-use, LOAD_LAT = 3: result_srcE = 01, RdE = 7, Rs2D = 7 for one cycle -> stallF/stallD/flushE high exactly 3 consecutive cycles, then low. RdE = 0 -> no stall.
- Branch cancels load stall: LOAD_LAT = 3, hazard at cycle 0, pc_srcE = 1 at cycle 1 -> cycle 1 flushD = flushE = 1, stallF = 0; cycle 2 all stalls 0.
- MDU: mdu_startE = 1 at cycle 0, mdu_done at cycle 4 -> stallF/D/E = flushM = 1 on cycles 0-3, all 0 on cycle 4, FSM IDLE on cycle 5. Start and done in the same cycle -> no stall.
- Async reset: assert rst_n = 0 at cycle 2 of an MDU busy period (mid-cycle, between edges) -> all stall/flush outputs 0 immediately; after release, FSM IDLE, lcnt = 0.
- With HAZARD_PERF_CNT_EN, run the MDU test -> stall_cycles = 4, flush_cycles = 4. Without the macro -> both read 0.
